// File: rtl/fpu_mul_normalizer.sv
// Back end of the single-precision multiply path. It takes the raw product
// from the multiplier front end. It normalizes the product, denormalizes it
// when needed and rounds to nearest-even. It then packs an IEEE-754 binary32
// result with its exception flags. Only one operation is in flight at a time.
module fpu_mul_normalizer #(
    parameter int MAX_DENORM_SHIFT = 26
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [9:0]  in_exp,
    input  logic [47:0] in_mantissa,
    input  logic        in_is_signalling1,
    input  logic        in_is_quiet1,
    input  logic        in_is_signalling2,
    input  logic        in_is_quiet2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_invalid,
    output logic        out_overflow,
    output logic        out_underflow,
    output logic        out_inexact
);

    localparam int CW = $clog2(MAX_DENORM_SHIFT + 1);

    typedef enum logic [2:0] {IDLE, ALIGN, DENORM, ROUND, DONE} state_t;

    state_t             state, state_n;
    logic               sign_q, sign_n;
    logic signed [9:0]  exp_q, exp_n;
    logic [47:0]        mant_q, mant_n;
    logic               sticky_q, sticky_n;
    logic               tiny_q, tiny_n;
    logic               snan_q, snan_n;
    logic               qnan_q, qnan_n;
    logic [CW-1:0]      cnt_q, cnt_n, cnt_inc;
    logic [31:0]        result_n;
    logic               invalid_n, overflow_n, underflow_n, inexact_n;

    logic signed [9:0]  align_exp;
    logic               inf_zero;
    logic               guard, sticky_all, round_up;
    logic [24:0]        round_sum;
    logic signed [9:0]  round_exp;
    logic               round_hidden;
    logic [22:0]        round_frac;
    logic               round_inexact;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    assign cnt_inc   = cnt_q + CW'(1);
    assign align_exp = mant_q[47] ? exp_q + 10'sd1 : exp_q;
    assign inf_zero  = (exp_q == 10'h0FF) && (mant_q[47:46] == 2'b11);

    // Round-to-nearest-even on the 24-bit significand. A carry out of the hidden bit renormalizes by one place.
    always_comb begin
        guard         = mant_q[22];
        sticky_all    = (|mant_q[21:0]) | sticky_q;
        round_up      = guard & (sticky_all | mant_q[23]);
        round_sum     = {1'b0, mant_q[46:23]} + {24'd0, round_up};
        round_exp     = round_sum[24] ? exp_q + 10'sd1 : exp_q;
        round_hidden  = round_sum[24] | round_sum[23];
        round_frac    = round_sum[24] ? 23'd0 : round_sum[22:0];
        round_inexact = guard | sticky_all;
    end

    // Next-state and datapath update for each phase of the operation.
    always_comb begin
        state_n     = state;
        sign_n      = sign_q;
        exp_n       = exp_q;
        mant_n      = mant_q;
        sticky_n    = sticky_q;
        tiny_n      = tiny_q;
        snan_n      = snan_q;
        qnan_n      = qnan_q;
        cnt_n       = cnt_q;
        result_n    = out_result;
        invalid_n   = out_invalid;
        overflow_n  = out_overflow;
        underflow_n = out_underflow;
        inexact_n   = out_inexact;

        case (state)
            IDLE: begin
                if (in_valid) begin
                    sign_n   = in_sign;
                    exp_n    = in_exp;
                    mant_n   = in_mantissa;
                    sticky_n = 1'b0;
                    tiny_n   = 1'b0;
                    cnt_n    = '0;
                    snan_n   = in_is_signalling1 | in_is_signalling2;
                    qnan_n   = in_is_quiet1 | in_is_quiet2;
                    state_n  = ALIGN;
                end
            end

            ALIGN: begin
                if (snan_q || qnan_q || inf_zero) begin
                    result_n    = 32'h7FC0_0000;
                    invalid_n   = snan_q | inf_zero;
                    overflow_n  = 1'b0;
                    underflow_n = 1'b0;
                    inexact_n   = 1'b0;
                    state_n     = DONE;
                end else if ((exp_q == 10'h0FF) && (mant_q == 48'h8000_0000_0000)) begin
                    result_n    = {sign_q, 8'hFF, 23'd0};
                    invalid_n   = 1'b0;
                    overflow_n  = 1'b0;
                    underflow_n = 1'b0;
                    inexact_n   = 1'b0;
                    state_n     = DONE;
                end else if ((exp_q == 10'h000) && (mant_q == 48'h8000_0000_0000)) begin
                    result_n    = {sign_q, 31'd0};
                    invalid_n   = 1'b0;
                    overflow_n  = 1'b0;
                    underflow_n = 1'b0;
                    inexact_n   = 1'b0;
                    state_n     = DONE;
                end else begin
                    mant_n   = mant_q[47] ? {1'b0, mant_q[47:1]} : mant_q;
                    sticky_n = sticky_q | (mant_q[47] & mant_q[0]);
                    exp_n    = align_exp;
                    state_n  = (align_exp < 10'sd1) ? DENORM : ROUND;
                end
            end

            DENORM: begin
                mant_n   = {1'b0, mant_q[47:1]};
                sticky_n = sticky_q | mant_q[0];
                exp_n    = exp_q + 10'sd1;
                tiny_n   = 1'b1;
                cnt_n    = cnt_inc;
                if (exp_q == 10'sd0) begin
                    state_n = ROUND;
                end else if (cnt_inc == CW'(MAX_DENORM_SHIFT)) begin
                    exp_n   = 10'sd1;
                    state_n = ROUND;
                end
            end

            ROUND: begin
                invalid_n = 1'b0;
                if (round_exp >= 10'sd255) begin
                    result_n    = {sign_q, 8'hFF, 23'd0};
                    overflow_n  = 1'b1;
                    inexact_n   = 1'b1;
                    underflow_n = tiny_q;
                end else begin
                    result_n    = {sign_q, (round_hidden ? round_exp[7:0] : 8'd0), round_frac};
                    overflow_n  = 1'b0;
                    inexact_n   = round_inexact;
                    underflow_n = tiny_q & round_inexact;
                end
                state_n = DONE;
            end

            DONE: begin
                if (out_ready) begin
                    state_n = IDLE;
                end
            end

            default: state_n = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            sign_q        <= 1'b0;
            exp_q         <= '0;
            mant_q        <= '0;
            sticky_q      <= 1'b0;
            tiny_q        <= 1'b0;
            snan_q        <= 1'b0;
            qnan_q        <= 1'b0;
            cnt_q         <= '0;
            out_result    <= '0;
            out_invalid   <= 1'b0;
            out_overflow  <= 1'b0;
            out_underflow <= 1'b0;
            out_inexact   <= 1'b0;
        end else begin
            state         <= state_n;
            sign_q        <= sign_n;
            exp_q         <= exp_n;
            mant_q        <= mant_n;
            sticky_q      <= sticky_n;
            tiny_q        <= tiny_n;
            snan_q        <= snan_n;
            qnan_q        <= qnan_n;
            cnt_q         <= cnt_n;
            out_result    <= result_n;
            out_invalid   <= invalid_n;
            out_overflow  <= overflow_n;
            out_underflow <= underflow_n;
            out_inexact   <= inexact_n;
        end
    end

endmodule

// File: doc/fpu_mul_normalizer.md
Name: fpu_mul_normalizer

Overview:
- Back end of the single-precision multiply path.
- Consumes the raw product from the multiplier front end: sign, 10-bit biased exponent, 48-bit unnormalized mantissa product and NaN flags.
- Normalizes, denormalizes, rounds (round-to-nearest-even) and packs an IEEE-754 binary32 result with exception flags.
- Valid/ready handshake on both sides; processes one operation at a time.

Parameters:
- MAX_DENORM_SHIFT, 26, cap on right-shift cycles in DENORM; beyond it the mantissa is all sticky.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand valid
- in_ready  out  1  block can accept
- in_sign  in  1  product sign
- in_exp  in  10  biased product exponent, two's complement
- in_mantissa  in  48  raw product; binary point between bits 46 and 45
- in_is_signalling1, in_is_quiet1, in_is_signalling2, in_is_quiet2  in  1 each  operand NaN flags
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts
- out_result  out  32  packed binary32
- out_invalid, out_overflow, out_underflow, out_inexact  out  1 each  exception flags, qualified by out_valid

Behaviour:
- Single clock clk; rst synchronous, active-high.
- Reset values:
  - state=IDLE, in_ready=1, out_valid=0, out_result=0, all flags 0.
  - Reset in any state aborts the operation; the captured operand is discarded.
- FSM states: IDLE, ALIGN, DENORM, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready, capture all inputs into an internal 48-bit mantissa register plus sticky bit (sticky=0) and go to ALIGN.
  - in_ready=0 in every other state.
- ALIGN (priority order):
  1. Any signalling flag, or any quiet flag, or (in_exp==10'h0FF & mant[47:46]==2'b11): result 0x7FC00000 (canonical qNaN, sign 0). invalid=1 if any signalling flag or the inf*0 pattern. Go to DONE.
  2. in_exp==10'h0FF & mant==48'h800000000000: infinity, {sign,8'hFF,23'd0}, no flags. Go to DONE.
  3. in_exp==0 & mant==48'h800000000000: signed zero, {sign,31'd0}, no flags. Go to DONE.
  4. Otherwise, if mant[47]==1: shift right 1, sticky|=shifted-out bit, exp+=1. Then if signed exp<1, go to DENORM, else go to ROUND.
- DENORM:
  - Per cycle: shift mant right 1, sticky|=bit0, exp+=1, set internal tiny=1.
  - Exit to ROUND when exp==1 or MAX_DENORM_SHIFT shifts have been done; on cap exit force exp=1.
- ROUND:
  - Bit map: bit46=hidden, bits45:23=fraction, bit22=guard, sticky_all = |bits21:0 | sticky.
  - Round up iff guard & (sticky_all | bit23).
  - inexact = guard | sticky_all.
  - Carry into bit47 → shift right 1, exp+=1.
  - Exponent field = mant[46] ? exp[7:0] : 0. This covers a subnormal rounding up to the minimum normal.
  - If signed exp>=255 after rounding: result {sign,8'hFF,0}, overflow=1, inexact=1.
  - underflow = tiny & inexact.
  - Go to DONE.
- DONE:
  - out_valid=1; out_result and flags held stable until out_ready.
  - On out_valid&out_ready → IDLE. The next input can be accepted the cycle after the handshake; no same-cycle pass-through.
- Latency (accept edge → out_valid high):
  - 2 cycles for special cases.
  - 3 cycles for normal results.
  - 3+k cycles for denormalized results, k = min(1-exp_after_align, MAX_DENORM_SHIFT).
- Arithmetic:
  - Exponent held as 10-bit signed; compares are signed.
  - 48-bit mantissa register plus 1 sticky bit; no bit beyond bit47 is ever needed.
- out_valid with out_ready low: no state change, outputs frozen.

Test Plan:
- 1.5*1.5: in_exp=127, in_mantissa=48'h900000000000, sign 0 → out_result=0x40100000, no flags, out_valid 3 cycles after accept.
- Specials:
  - in_exp=10'h0FF, mant=48'hC00000000000, sign 1 → 0x7FC00000, invalid=1, latency 2.
  - in_is_signalling2=1 → 0x7FC00000, invalid=1.
  - in_exp=0, mant=48'h800000000000, sign 1 → 0x80000000.
- Overflow: in_exp=10'h100, mant=48'h400000000000 → 0x7F800000, overflow=1, inexact=1.
- Denormal: in_exp=10'h3FF (-1), mant=48'h400000000000 → 0x00200000, underflow=0, inexact=0, latency 5. Second case: in_exp=10'h3C0 → cap exit, result 0x00000000, underflow=1, inexact=1.
- RNE:
  - in_exp=127, mant=48'h400000400000 (tie, even) → 0x3F800000, inexact=1.
  - mant=48'h400000C00000 → 0x3F800002.
  - mant=48'h7FFFFFC00000 → carry, 0x40000000.
- Handshake/reset:
  - Hold out_ready=0 for 5 cycles → out_result stable, in_ready=0, second in_valid ignored.
  - Assert rst during DENORM → next cycle out_valid=0, in_ready=1, and the next operation's result is correct.
